display_event_scheduler: RTL and testbench
==========================================

# display_event_scheduler

Time-multiplexes the single 3-bit status display between six concurrent home events: fire alarm, front door, rear door, window, heater and cooler. Each active event is shown for a fixed dwell period, in round-robin order. The fire alarm pre-empts every other event. The block sits between the integ controller's actuator outputs and the display driver, and it replaces the direct one-code-at-a-time display path.

## Interface
- DWELL, 8: cycles each event code is held on the display; legal range 2..2^CW.
- CW, 4: dwell counter width.
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- alarm_req  in  1  fire alarm active (integ alarmbuzz); index 0.
- fdoor_req  in  1  front door open (integ fdoor); index 1.
- rdoor_req  in  1  rear door open (integ rdoor); index 2.
- win_req  in  1  window buzzer active (integ winbuzz); index 3.
- heat_req  in  1  heater on; index 4.
- cool_req  in  1  cooler on; index 5.
- display  out  3  shown event code, registered: idle=0, alarm=1, fdoor=2, rdoor=3, window=4, heater=5, cooler=6. Code 7 is never driven.
- active  out  1  registered; high whenever the state is not IDLE.
- pending  out  6  registered sticky request latch, bit i = index i.

## Operation
- req[5:0] is the request inputs by index. eligible = req | pending.
- pending[i] is set on any edge where req[i]=1.
- pending[i] is cleared only when index i completes its display slot while req[i]=0. If set and clear coincide, set wins.
- Single-cycle request pulses are therefore never lost.
- ptr[2:0] holds the last completed non-alarm index (1..5).
- Round-robin pick: the first eligible index, excluding index 0, searching ptr+1, ptr+2, … with 5 wrapping to 1.
- The FSM has three states: IDLE, SHOW, ALARM.
- IDLE:
  - display=0.
  - If eligible[0], go to ALARM.
  - Else if any eligible[5:1], go to SHOW with cur = pick and cnt = DWELL-1.
- SHOW:
  - display = cur+1.
  - If alarm_req=1, go to ALARM on the next edge. The slot is abandoned: pending[cur] is kept and ptr is unchanged.
  - Else cnt decrements each cycle.
  - At cnt=0 the slot completes: ptr=cur and pending[cur] clear rule applies.
  - Next step after completion: ALARM if eligible[0], else SHOW(pick) if any eligible[5:1], else IDLE.
  - If only cur is still eligible, re-enter SHOW for the same cur with no idle gap.
- ALARM:
  - display=1.
  - While alarm_req=1, cnt is held at DWELL-1.
  - Once alarm_req=0, cnt decrements. If alarm_req rises again, cnt reloads.
  - At cnt=0, clear pending[0] and choose next as in SHOW, but ignoring index 0.
- Arithmetic: cnt is unsigned CW bits and never wraps; it is always reloaded before it would underflow.
- ptr advances only on slot completion.

## Timing
- Reset value of every output and register is 0, except ptr=5 so the first search starts at index 1. The FSM resets to IDLE.
- Reset is asynchronous. Asserting Rst mid-slot forces display=0, active=0 and pending=0 immediately. Operation resumes on the first edge after Rst deasserts.
- Latency: a request sampled high at edge k, with the FSM in IDLE, drives display = code from edge k on.
- Alarm pre-emption from SHOW: display=1 from the edge at which alarm_req is first sampled high.
- A SHOW slot holds its code for exactly DWELL cycles.
- ALARM holds for exactly DWELL cycles after the last edge where alarm_req was sampled high.
- There is no idle cycle between consecutive slots while any request is eligible.

## Test plan
- Reset and single request, DWELL=4:
  - Stimulus: hold Rst low, release, assert fdoor_req for one cycle at edge 3.
  - Required: all outputs 0 during reset; display=2 and active=1 for edges 3–6; pending[1] cleared at edge 6; display=0 and active=0 from edge 7.
- Round robin:
  - Stimulus: hold fdoor_req, win_req and cool_req high.
  - Required: display sequence 2,4,6,2,4,6…, each code lasting 4 cycles with no 0 gaps.
- Alarm pre-emption:
  - Stimulus: during SHOW(3) at cnt=1, pulse alarm_req for 2 cycles.
  - Required: display=1 from the next edge and held for 2+4 cycles; then display=3 again for a full 4 cycles, since pending[2] was retained.
- Pulse capture:
  - Stimulus: while heater is showing, pulse rdoor_req for 1 cycle.
  - Required: pending[2]=1 at the next edge; rdoor (code 3) is shown once after the heater slot completes; pending[2]=0 afterwards.
- Async reset mid-alarm:
  - Stimulus: drive Rst low with no clock edge during ALARM.
  - Required: display=0, active=0, pending=0 immediately.
  - Stimulus: release with no requests.
  - Required: the block stays IDLE.
- Sole persistent request:
  - Stimulus: hold cool_req high for 12 cycles.
  - Required: display=6 continuously with active=1; back-to-back slots reload cnt.
  - Stimulus: drop cool_req.
  - Required: the current slot finishes, then display=0.

Source files
------------

// File: rtl/display_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : display_event_scheduler
// Brief    : Round-robin time-multiplexing of six home events onto one 3-bit
//            status display, with fire-alarm pre-emption and sticky requests.
// Revision : 1.0
// ============================================================================
module display_event_scheduler #(
    parameter int DWELL = 8,
    parameter int CW    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm_req,
    input  logic       fdoor_req,
    input  logic       rdoor_req,
    input  logic       win_req,
    input  logic       heat_req,
    input  logic       cool_req,
    output logic [2:0] display,
    output logic       active,
    output logic [5:0] pending
);

    localparam logic [CW-1:0] c_reload = (CW)'(DWELL - 1);
    localparam logic [CW-1:0] c_one    = (CW)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_cur, w_cur_nxt;
    logic [2:0]    r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_alarm_q;
    logic [5:0]    w_req, w_elig, w_clr, w_pend_nxt;
    logic [2:0]    w_pick, w_disp_nxt;

    // First eligible non-alarm index after 'last', wrapping 5 -> 1; 0 if none.
    function automatic logic [2:0] rr_pick(input logic [5:1] elig, input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] hit;
        hit = 3'd0;
        idx = last;
        for (int k = 0; k < 5; k++) begin
            idx = (idx >= 3'd5) ? 3'd1 : idx + 3'd1;
            if (hit == 3'd0 && elig[idx]) hit = idx;
        end
        return hit;
    endfunction

    always_comb begin
        w_req       = {cool_req, heat_req, win_req, rdoor_req, fdoor_req, alarm_req};
        w_elig      = w_req | pending;
        w_pick      = rr_pick(w_elig[5:1], r_ptr);
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_clr       = 6'd0;

        case (r_state)
            ST_IDLE: begin
                if (w_elig[0]) begin
                    w_state_nxt = ST_ALARM;
                    w_cnt_nxt   = c_reload;
                end else if (w_pick != 3'd0) begin
                    w_state_nxt = ST_SHOW;
                    w_cur_nxt   = w_pick;
                    w_cnt_nxt   = c_reload;
                end
            end
            ST_SHOW: begin
                if (alarm_req) begin
                    w_state_nxt = ST_ALARM;
                    w_cnt_nxt   = c_reload;
                end else if (r_cnt == '0) begin
                    if (w_elig[0]) begin
                        w_state_nxt = ST_ALARM;
                        w_cnt_nxt   = c_reload;
                    end else if (w_pick != 3'd0) begin
                        w_cur_nxt = w_pick;
                        w_cnt_nxt = c_reload;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    // Slot bookkeeping happens on the edge that enters the last cycle.
                    w_cnt_nxt = r_cnt - c_one;
                    if (r_cnt == c_one) begin
                        w_ptr_nxt    = r_cur;
                        w_clr[r_cur] = 1'b1;
                    end
                end
            end
            ST_ALARM: begin
                if (alarm_req || r_alarm_q) begin
                    // Countdown starts only on the second low edge so the full
                    // dwell follows the last edge the alarm was seen high.
                    w_cnt_nxt = c_reload;
                end else if (r_cnt == '0) begin
                    if (w_pick != 3'd0) begin
                        w_state_nxt = ST_SHOW;
                        w_cur_nxt   = w_pick;
                        w_cnt_nxt   = c_reload;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                    if (r_cnt == c_one) w_clr[0] = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_pend_nxt = (pending & ~w_clr) | w_req;

        case (w_state_nxt)
            ST_SHOW:  w_disp_nxt = w_cur_nxt + 3'd1;
            ST_ALARM: w_disp_nxt = 3'd1;
            default:  w_disp_nxt = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cur     <= 3'd0;
            r_ptr     <= 3'd5;
            r_cnt     <= '0;
            r_alarm_q <= 1'b0;
            pending   <= 6'd0;
            display   <= 3'd0;
            active    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur     <= w_cur_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_alarm_q <= alarm_req;
            pending   <= w_pend_nxt;
            display   <= w_disp_nxt;
            active    <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_event_scheduler
// Brief    : Directed and randomized bench for display_event_scheduler
//            against a cycles-remaining reference model.
// Revision : 1.0
// ============================================================================
module tb_display_event_scheduler;

    localparam int DWELL = 4;
    localparam int CW    = 4;

    localparam logic [5:0] c_alarm = 6'h01;
    localparam logic [5:0] c_fdoor = 6'h02;
    localparam logic [5:0] c_rdoor = 6'h04;
    localparam logic [5:0] c_win   = 6'h08;
    localparam logic [5:0] c_heat  = 6'h10;
    localparam logic [5:0] c_cool  = 6'h20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alarm_req = 1'b0, fdoor_req = 1'b0, rdoor_req = 1'b0;
    logic       win_req = 1'b0, heat_req = 1'b0, cool_req = 1'b0;
    logic [2:0] display;
    logic       active;
    logic [5:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 showing an event, 2 alarm.
    int         m_mode, m_idx, m_left, m_last;
    logic [5:0] m_pend;

    display_event_scheduler #(.DWELL(DWELL), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alarm_req(alarm_req), .fdoor_req(fdoor_req), .rdoor_req(rdoor_req),
        .win_req(win_req), .heat_req(heat_req), .cool_req(cool_req),
        .display(display), .active(active), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_left = 0; m_last = 5; m_pend = 6'd0;
    endtask

    function automatic int rr_next(input logic [5:0] elig);
        for (int k = 1; k <= 5; k++) begin
            int i;
            i = (m_last - 1 + k) % 5 + 1;
            if (elig[i]) return i;
        end
        return 0;
    endfunction

    // Alarm shows its sampled-high cycle plus a full dwell afterwards.
    task automatic start_alarm();
        m_mode = 2; m_left = DWELL + 1;
    endtask

    task automatic model_edge(input logic [5:0] r);
        logic [5:0] elig, clr;
        int nxt;
        elig = r | m_pend;
        clr  = 6'd0;
        case (m_mode)
            0: begin
                if (elig[0]) start_alarm();
                else begin
                    nxt = rr_next(elig);
                    if (nxt != 0) begin m_mode = 1; m_idx = nxt; m_left = DWELL; end
                end
            end
            1: begin
                if (r[0]) start_alarm();
                else if (m_left == 1) begin
                    if (elig[0]) start_alarm();
                    else begin
                        nxt = rr_next(elig);
                        if (nxt != 0) begin m_idx = nxt; m_left = DWELL; end
                        else m_mode = 0;
                    end
                end else begin
                    m_left--;
                    if (m_left == 1) begin m_last = m_idx; clr[m_idx] = 1'b1; end
                end
            end
            default: begin
                if (r[0]) m_left = DWELL + 1;
                else if (m_left == 1) begin
                    nxt = rr_next(elig);
                    if (nxt != 0) begin m_mode = 1; m_idx = nxt; m_left = DWELL; end
                    else m_mode = 0;
                end else begin
                    m_left--;
                    if (m_left == 1) clr[0] = 1'b1;
                end
            end
        endcase
        m_pend = (m_pend & ~clr) | r;
    endtask

    function automatic int m_disp();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 1;
        return m_idx + 1;
    endfunction

    task automatic set_req(input logic [5:0] r);
        {cool_req, heat_req, win_req, rdoor_req, fdoor_req, alarm_req} = r;
    endtask

    task automatic step(input logic [5:0] r);
        @(negedge clk);
        set_req(r);
        @(posedge clk);
        model_edge(r);
        #1;
        check("display", display, m_disp());
        check("active", active, (m_mode != 0));
        check("pending", pending, m_pend);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_display"}, display, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_pending"}, pending, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_req(6'd0);
        #1;
        check_zero("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (m_mode == 0 && display == 3'd0) break;
            step(6'd0);
        end
        check("drain_idle", display, 0);
    endtask

    int rr_codes[3]  = '{2, 4, 6};
    int pre_exp[11]  = '{1, 1, 1, 1, 1, 1, 3, 3, 3, 3, 0};
    int shown;
    logic [5:0] rnd;

    initial begin
        model_reset();
        do_reset();

        // Single one-cycle front-door request at edge 3.
        step(6'd0);
        step(6'd0);
        step(c_fdoor);
        check("t1_disp", display, 2);
        check("t1_active", active, 1);
        for (int i = 0; i < 3; i++) begin
            step(6'd0);
            check("t1_hold", display, 2);
        end
        check("t1_pend_cleared", pending[1], 0);
        step(6'd0);
        check("t1_idle_disp", display, 0);
        check("t1_idle_active", active, 0);

        // Round robin over three held requests from a fresh pointer.
        do_reset();
        for (int n = 0; n < 24; n++) begin
            step(c_fdoor | c_win | c_cool);
            check("rr_seq", display, rr_codes[(n / 4) % 3]);
        end
        drain();

        // Alarm pre-empts rdoor slot at its last-but-one cycle.
        step(c_rdoor);
        step(6'd0);
        step(6'd0);
        for (int n = 0; n < 11; n++) begin
            step(n < 2 ? c_alarm : 6'd0);
            check("pre_seq", display, pre_exp[n]);
        end
        drain();

        // One-cycle rdoor pulse during a heater slot.
        step(c_heat);
        step(c_rdoor);
        check("pc_pend2_set", pending[2], 1);
        shown = 0;
        for (int n = 0; n < 16; n++) begin
            step(6'd0);
            if (display == 3'd3) shown++;
        end
        check("pc_rdoor_cycles", shown, DWELL);
        check("pc_pend2_clear", pending[2], 0);

        // Asynchronous reset during alarm, away from any clock edge.
        step(c_alarm);
        step(6'd0);
        #2 rst_n = 1'b0;
        #1;
        check_zero("ar_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("ar_hold");
        #2 rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(6'd0);
            check("ar_stay_idle", display, 0);
        end

        // Sole persistent cooler request.
        for (int n = 0; n < 12; n++) begin
            step(c_cool);
            check("cool_disp", display, 6);
            check("cool_active", active, 1);
        end
        drain();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            rnd[0] = ($urandom_range(0, 39) == 0);
            for (int b = 1; b < 6; b++) rnd[b] = ($urandom_range(0, 5) == 0);
            step(rnd);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
